// File: rtl/midi_interface_adapter.sv
// MIDI DIN receiver (UART 8N1) and channel-voice message parser.
// Optional feature macro: MIDI_RUNNING_STATUS_EN (running status for data bytes).
module midi_interface_adapter #(
  parameter int CLK_HZ = 12_000_000,
  parameter int BAUD   = 31_250
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       MIDI_IN,
  output logic [7:0] MIDI_CMD,
  output logic [7:0] MIDI_DAT_0,
  output logic [7:0] MIDI_DAT_1,
  output logic       CMD_READY,
  output logic       DATA_READY
);
  localparam int BIT_CLKS = CLK_HZ / BAUD;
  localparam int CW = $clog2(BIT_CLKS);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CLKS / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(BIT_CLKS - 1);

`ifdef MIDI_RUNNING_STATUS_EN
  localparam bit RUNNING_STATUS = 1'b1;
`else
  localparam bit RUNNING_STATUS = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  rx_state_t       state, state_nxt;
  logic [1:0]      sync;
  logic            rx, rx_prev;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            ferr;
  logic            byte_valid;
  logic            tick_half, tick_full;

  // NOTE: the synchronizer resets to the idle level so reset never fakes a start edge.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync    <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync    <= {sync[0], MIDI_IN};
      rx_prev <= sync[1];
    end
  end
  assign rx = sync[1];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (rx_prev && !rx) state_nxt = START;
      START: if (tick_half) state_nxt = rx ? IDLE : DATA;
      DATA:  if (tick_full && bit_idx == 3'd7) state_nxt = STOP;
      STOP:  if (ferr ? rx : (tick_full && rx)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every comb output gets a default first so no latch is inferred.
  always_comb begin
    tick_half = 1'b0;
    tick_full = 1'b0;
    if (state == START && cnt == HALF_LAST) tick_half = 1'b1;
    if ((state == DATA || state == STOP) && !ferr && cnt == FULL_LAST) tick_full = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      ferr       <= 1'b0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      cnt        <= (state == IDLE || tick_half || tick_full) ? '0 : cnt + 1'b1;
      if (state == IDLE) begin
        bit_idx <= '0;
        ferr    <= 1'b0;
      end
      if (state == DATA && tick_full) begin
        shreg   <= {rx, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (state == STOP && tick_full) begin
        if (rx) byte_valid <= 1'b1;
        else    ferr       <= 1'b1;
      end
    end
  end

  logic [7:0] held;
  logic       idx;
  logic       hold_off;
  logic       one_byte;

  assign one_byte = (MIDI_CMD[7:4] == 4'hC) || (MIDI_CMD[7:4] == 4'hD);

  // Reset has priority over a byte arriving in the same cycle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      MIDI_CMD   <= 8'h00;
      MIDI_DAT_0 <= 8'h00;
      MIDI_DAT_1 <= 8'h00;
      CMD_READY  <= 1'b0;
      DATA_READY <= 1'b0;
      held       <= 8'h00;
      idx        <= 1'b0;
      hold_off   <= 1'b0;
    end else begin
      CMD_READY  <= 1'b0;
      DATA_READY <= 1'b0;
      if (byte_valid) begin
        if (shreg >= 8'hF8) begin
          // real-time: transparent to the parser
        end else if (shreg >= 8'hF0) begin
          MIDI_CMD <= 8'h00;
          idx      <= 1'b0;
        end else if (shreg[7]) begin
          MIDI_CMD  <= shreg;
          idx       <= 1'b0;
          hold_off  <= 1'b0;
          CMD_READY <= 1'b1;
        end else if (MIDI_CMD != 8'h00 && !hold_off) begin
          if (one_byte) begin
            MIDI_DAT_0 <= shreg;
            MIDI_DAT_1 <= 8'h00;
            DATA_READY <= 1'b1;
            hold_off   <= !RUNNING_STATUS;
          end else if (!idx) begin
            held <= shreg;
            idx  <= 1'b1;
          end else begin
            MIDI_DAT_0 <= held;
            MIDI_DAT_1 <= shreg;
            DATA_READY <= 1'b1;
            idx        <= 1'b0;
            hold_off   <= !RUNNING_STATUS;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_midi_interface_adapter.sv
// Scoreboard bench for midi_interface_adapter: serial stimulus, message-level reference model.
module tb_midi_interface_adapter;
  localparam int CLK_HZ = 2_000_000;
  localparam int BAUD   = 31_250;
  localparam int BIT    = CLK_HZ / BAUD;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       MIDI_IN;
  logic [7:0] MIDI_CMD, MIDI_DAT_0, MIDI_DAT_1;
  logic       CMD_READY, DATA_READY;

  midi_interface_adapter #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .MIDI_IN(MIDI_IN),
    .MIDI_CMD(MIDI_CMD), .MIDI_DAT_0(MIDI_DAT_0), .MIDI_DAT_1(MIDI_DAT_1),
    .CMD_READY(CMD_READY), .DATA_READY(DATA_READY)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit         is_data;
    logic [7:0] cmd;
    logic [7:0] d0;
    logic [7:0] d1;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_err = 0;
  int         unstable = 0;

  logic [7:0] m_cmd = 8'h00;
  logic [7:0] m_data[$];
  bit         m_locked = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_cmd = 8'h00;
    m_data.delete();
    m_locked = 1'b0;
  endtask

  // Message-level rules: status classes, data-byte count per command, running status.
  task automatic model_byte(input logic [7:0] b);
    int need;
    if (b >= 8'hF8) return;
    if (b >= 8'hF0) begin
      m_cmd = 8'h00;
      m_data.delete();
      return;
    end
    if (b[7]) begin
      m_cmd = b;
      m_data.delete();
      m_locked = 1'b0;
      exp_q.push_back('{1'b0, b, 8'h00, 8'h00});
      return;
    end
    if (m_cmd == 8'h00 || m_locked) return;
    m_data.push_back(b);
    need = (m_cmd[7:4] == 4'hC || m_cmd[7:4] == 4'hD) ? 1 : 2;
    if (m_data.size() == need) begin
      if (need == 2) exp_q.push_back('{1'b1, m_cmd, m_data[0], m_data[1]});
      else           exp_q.push_back('{1'b1, m_cmd, m_data[0], 8'h00});
      m_data.delete();
`ifndef MIDI_RUNNING_STATUS_EN
      m_locked = 1'b1;
`endif
    end
  endtask

  task automatic drive(input logic v, input int n);
    MIDI_IN = v;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop = 1'b1);
    if (good_stop) model_byte(b);
    drive(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(b[i], BIT);
    drive(good_stop, BIT);
    drive(1'b1, $urandom_range(4, 40));
  endtask

  // Monitor: pops one expectation per output strobe.
  logic [7:0] p0 = 8'h00, p1 = 8'h00;
  always @(posedge sys_clk) begin
    exp_t e;
    #1;
    if (CMD_READY || DATA_READY) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, CMD_READY, DATA_READY}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", {31'd0, DATA_READY}, {31'd0, e.is_data});
        check("midi_cmd", MIDI_CMD, e.cmd);
        if (e.is_data) begin
          check("dat_0", MIDI_DAT_0, e.d0);
          check("dat_1", MIDI_DAT_1, e.d1);
        end
      end
    end
    if (!sys_rst && !DATA_READY && (MIDI_DAT_0 != p0 || MIDI_DAT_1 != p1)) unstable++;
    p0 = MIDI_DAT_0;
    p1 = MIDI_DAT_1;
  end

  initial begin
    logic [7:0] b;
    int         r;
    sys_rst = 1'b1;
    MIDI_IN = 1'b1;
    repeat (4) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("rst_cmd", MIDI_CMD, 8'h00);
    check("rst_dat_0", MIDI_DAT_0, 8'h00);
    check("rst_dat_1", MIDI_DAT_1, 8'h00);
    check("rst_cmd_ready", {31'd0, CMD_READY}, 32'd0);
    check("rst_data_ready", {31'd0, DATA_READY}, 32'd0);

    // Note-on, then running-status data, then program change.
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
    send_byte(8'h40); send_byte(8'h00);
    send_byte(8'hC2); send_byte(8'h05);
    check("pc_cmd", MIDI_CMD, 8'hC2);

    // Real-time inside a message, then SysEx cancelling the status.
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'hF8); send_byte(8'h64);
    send_byte(8'h90); send_byte(8'hF0); send_byte(8'h3C);
    check("sysex_clears_cmd", MIDI_CMD, 8'h00);

    // Line errors: short glitch and a framing error, then a clean message.
    drive(1'b0, BIT * 100 / 384);
    drive(1'b1, 3 * BIT);
    send_byte(8'h55, 1'b0);
    send_byte(8'h80); send_byte(8'h3C); send_byte(8'h00);

    // Reset during data bit 4 with a data byte pending.
    send_byte(8'h90); send_byte(8'h45);
    b = 8'h3C;
    drive(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(b[i], BIT);
    drive(b[4], BIT / 2);
    sys_rst = 1'b1;
    model_reset();
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    drive(1'b1, 2 * BIT);
    check("midrst_cmd", MIDI_CMD, 8'h00);
    check("midrst_dat_0", MIDI_DAT_0, 8'h00);
    check("midrst_dat_1", MIDI_DAT_1, 8'h00);
    check("midrst_queue", exp_q.size(), 32'd0);
    send_byte(8'h90); send_byte(8'h45); send_byte(8'h7F);

    // Random traffic.
    for (int n = 0; n < 50; n++) begin
      r = $urandom_range(0, 15);
      if (r <= 3)       send_byte(8'h80 + 8'($urandom_range(0, 8'h6F)));
      else if (r <= 11) send_byte(8'($urandom_range(0, 8'h7F)));
      else if (r == 12) send_byte(8'hF8 + 8'($urandom_range(0, 7)));
      else if (r == 13) send_byte(8'hF0 + 8'($urandom_range(0, 7)));
      else if (r == 14) send_byte(8'($urandom_range(0, 255)), 1'b0);
      else begin
        drive(1'b0, $urandom_range(2, BIT / 3));
        drive(1'b1, 2 * BIT);
      end
    end

    drive(1'b1, 2 * BIT);
    check("queue_drained", exp_q.size(), 32'd0);
    check("dat_stable", unstable, 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
